// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store unit: aligns core accesses onto a word-wide memory port
module load_store_unit #(
  parameter int XLEN    = 64,
  parameter int ADDR_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              in_Clk,
  input  logic              in_Rst_N,
  input  logic              in_req_valid,
  output logic              out_req_ready,
  input  logic              in_req_we,
  input  logic [1:0]        in_req_size,
  input  logic              in_req_unsigned,
  input  logic [ADDR_W-1:0] in_req_addr,
  input  logic [XLEN-1:0]   in_req_wdata,
  output logic              out_resp_valid,
  output logic [XLEN-1:0]   out_resp_data,
  output logic              out_resp_err,
  output logic              out_mem_valid,
  output logic              out_mem_we,
  input  logic              in_mem_ready,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic [XLEN-1:0]   out_mem_wdata,
  output logic [XLEN/8-1:0] out_mem_be,
  input  logic              in_mem_rvalid,
  input  logic [XLEN-1:0]   in_mem_rdata
);
  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              req_we_q, req_we_d;
  logic              req_unsigned_q, req_unsigned_d;
  logic [1:0]        req_size_q, req_size_d;
  logic [OFF_W-1:0]  req_off_q, req_off_d;
  logic              req_ready_q, req_ready_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;

  logic [OFF_W-1:0]  in_off;
  logic              misaligned, illegal;
  logic [BE_W-1:0]   size_mask;
  logic [XLEN-1:0]   rd_shift, rd_mask, rd_ext;
  int                nbytes, nbits;

  always_comb begin
    in_off    = in_req_addr[OFF_W-1:0];
    nbytes    = 1 << in_req_size;
    size_mask = BE_W'((32'd1 << nbytes) - 32'd1);
    case (in_req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = in_req_addr[0];
      2'b10:   misaligned = |in_req_addr[1:0];
      default: misaligned = |in_req_addr[2:0];
    endcase
    illegal = misaligned || (in_req_size == 2'b11 && XLEN == 32);

    // Load return: move the addressed lane to bit 0, keep size bits, then extend.
    nbits = 8 << req_size_q;
    if (nbits > XLEN) nbits = XLEN;
    rd_shift = in_mem_rdata >> {req_off_q, 3'b000};
    rd_mask  = (nbits == XLEN) ? '1 : ((XLEN'(1) << nbits) - XLEN'(1));
    rd_ext   = rd_shift & rd_mask;
    if (!req_unsigned_q && (|(rd_shift & (XLEN'(1) << (nbits - 1)))))
      rd_ext = rd_ext | ~rd_mask;
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    req_we_d       = req_we_q;
    req_unsigned_d = req_unsigned_q;
    req_size_d     = req_size_q;
    req_off_d      = req_off_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_be_d       = mem_be_q;
    resp_valid_d   = 1'b0;
    resp_data_d    = '0;
    resp_err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_req_valid) begin
          req_we_d       = in_req_we;
          req_unsigned_d = in_req_unsigned;
          req_size_d     = in_req_size;
          req_off_d      = in_off;
          cnt_d          = '0;
          mem_we_d       = in_req_we;
          mem_addr_d     = {in_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          mem_wdata_d    = in_req_wdata << {in_off, 3'b000};
          mem_be_d       = in_req_we ? (size_mask << in_off) : '0;
          if (illegal) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (in_mem_ready) begin
          cnt_d = '0;
          if (req_we_q) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
          end else begin
            state_d = WAIT_R;
          end
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WAIT_R: begin
        if (in_mem_rvalid) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_data_d  = rd_ext;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    mem_valid_d = (state_d == REQ);
    // Memory-side fields are only meaningful while a request is outstanding.
    if (state_d != REQ) begin
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      mem_be_d    = '0;
    end
  end

  always_ff @(posedge in_Clk) begin
    if (!in_Rst_N) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      req_we_q       <= 1'b0;
      req_unsigned_q <= 1'b0;
      req_size_q     <= '0;
      req_off_q      <= '0;
      req_ready_q    <= 1'b1;
      mem_valid_q    <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_be_q       <= '0;
      resp_valid_q   <= 1'b0;
      resp_data_q    <= '0;
      resp_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      req_we_q       <= req_we_d;
      req_unsigned_q <= req_unsigned_d;
      req_size_q     <= req_size_d;
      req_off_q      <= req_off_d;
      req_ready_q    <= req_ready_d;
      mem_valid_q    <= mem_valid_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_be_q       <= mem_be_d;
      resp_valid_q   <= resp_valid_d;
      resp_data_q    <= resp_data_d;
      resp_err_q     <= resp_err_d;
    end
  end

  assign out_req_ready  = req_ready_q;
  assign out_mem_valid  = mem_valid_q;
  assign out_mem_we     = mem_we_q;
  assign out_mem_addr   = mem_addr_q;
  assign out_mem_wdata  = mem_wdata_q;
  assign out_mem_be     = mem_be_q;
  assign out_resp_valid = resp_valid_q;
  assign out_resp_data  = resp_data_q;
  assign out_resp_err   = resp_err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed vector bench for load_store_unit (64-bit and 32-bit instances)
module tb_load_store_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, sel32, req_valid, req_we, req_unsigned, mem_ready, mem_rvalid;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata, mem_rdata;

  logic        a_ready, a_resp_valid, a_resp_err, a_mem_valid, a_mem_we;
  logic [63:0] a_resp_data, a_mem_addr, a_mem_wdata;
  logic [7:0]  a_mem_be;
  logic        b_ready, b_resp_valid, b_resp_err, b_mem_valid, b_mem_we;
  logic [31:0] b_resp_data, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_be;

  load_store_unit #(.XLEN(64), .ADDR_W(64), .TIMEOUT(4)) dut64 (
    .in_Clk(clk), .in_Rst_N(rst_n),
    .in_req_valid(req_valid && !sel32), .out_req_ready(a_ready),
    .in_req_we(req_we), .in_req_size(req_size), .in_req_unsigned(req_unsigned),
    .in_req_addr(req_addr), .in_req_wdata(req_wdata),
    .out_resp_valid(a_resp_valid), .out_resp_data(a_resp_data), .out_resp_err(a_resp_err),
    .out_mem_valid(a_mem_valid), .out_mem_we(a_mem_we), .in_mem_ready(mem_ready && !sel32),
    .out_mem_addr(a_mem_addr), .out_mem_wdata(a_mem_wdata), .out_mem_be(a_mem_be),
    .in_mem_rvalid(mem_rvalid && !sel32), .in_mem_rdata(mem_rdata)
  );

  load_store_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
    .in_Clk(clk), .in_Rst_N(rst_n),
    .in_req_valid(req_valid && sel32), .out_req_ready(b_ready),
    .in_req_we(req_we), .in_req_size(req_size), .in_req_unsigned(req_unsigned),
    .in_req_addr(req_addr[31:0]), .in_req_wdata(req_wdata[31:0]),
    .out_resp_valid(b_resp_valid), .out_resp_data(b_resp_data), .out_resp_err(b_resp_err),
    .out_mem_valid(b_mem_valid), .out_mem_we(b_mem_we), .in_mem_ready(mem_ready && sel32),
    .out_mem_addr(b_mem_addr), .out_mem_wdata(b_mem_wdata), .out_mem_be(b_mem_be),
    .in_mem_rvalid(mem_rvalid && sel32), .in_mem_rdata(mem_rdata[31:0])
  );

  logic        o_ready, o_resp_valid, o_resp_err, o_mem_valid, o_mem_we;
  logic [63:0] o_resp_data, o_mem_addr, o_mem_wdata;
  logic [7:0]  o_mem_be;
  assign o_ready      = sel32 ? b_ready      : a_ready;
  assign o_resp_valid = sel32 ? b_resp_valid : a_resp_valid;
  assign o_resp_err   = sel32 ? b_resp_err   : a_resp_err;
  assign o_mem_valid  = sel32 ? b_mem_valid  : a_mem_valid;
  assign o_mem_we     = sel32 ? b_mem_we     : a_mem_we;
  assign o_resp_data  = sel32 ? {32'd0, b_resp_data} : a_resp_data;
  assign o_mem_addr   = sel32 ? {32'd0, b_mem_addr}  : a_mem_addr;
  assign o_mem_wdata  = sel32 ? {32'd0, b_mem_wdata} : a_mem_wdata;
  assign o_mem_be     = sel32 ? {4'd0, b_mem_be}     : a_mem_be;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr, wdata, rdata;
    logic        err;
    logic [63:0] e_addr;
    logic [7:0]  e_be;
    logic [63:0] e_wdata, e_data;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [63:0] addr, wdata, rdata, input logic err,
                              input logic [63:0] e_addr, input logic [7:0] e_be,
                              input logic [63:0] e_wdata, e_data);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.err = err; v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata; v.e_data = e_data;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input vec_t v, input string tag);
    chk({tag, ".ready"}, 64'(o_ready), 64'd1);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    step();
    req_valid = 1'b0;
    if (v.err) begin
      chk({tag, ".err_memv"}, 64'(o_mem_valid), 64'd0);
      chk({tag, ".err_rv"}, 64'(o_resp_valid), 64'd1);
      chk({tag, ".err_flag"}, 64'(o_resp_err), 64'd1);
      chk({tag, ".err_data"}, o_resp_data, 64'd0);
    end else begin
      chk({tag, ".memv"}, 64'(o_mem_valid), 64'd1);
      chk({tag, ".memwe"}, 64'(o_mem_we), 64'(v.we));
      chk({tag, ".addr"}, o_mem_addr, v.e_addr);
      chk({tag, ".be"}, 64'(o_mem_be), 64'(v.e_be));
      if (v.we) chk({tag, ".wdata"}, o_mem_wdata, v.e_wdata);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      if (v.we) begin
        chk({tag, ".st_rv"}, 64'(o_resp_valid), 64'd1);
        chk({tag, ".st_err"}, 64'(o_resp_err), 64'd0);
        chk({tag, ".st_data"}, o_resp_data, 64'd0);
      end else begin
        chk({tag, ".ld_early"}, 64'(o_resp_valid), 64'd0);
        chk({tag, ".ld_memv"}, 64'(o_mem_valid), 64'd0);
        mem_rvalid = 1'b1; mem_rdata = v.rdata;
        step();
        mem_rvalid = 1'b0;
        chk({tag, ".ld_rv"}, 64'(o_resp_valid), 64'd1);
        chk({tag, ".ld_err"}, 64'(o_resp_err), 64'd0);
        chk({tag, ".ld_data"}, o_resp_data, v.e_data);
      end
    end
    step();
    chk({tag, ".pulse"}, 64'(o_resp_valid), 64'd0);
    chk({tag, ".idle_data"}, o_resp_data, 64'd0);
    chk({tag, ".idle_ready"}, 64'(o_ready), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  initial begin
    vec_t v64[$];
    vec_t v32[$];
    // we size uns addr wdata rdata err | e_addr e_be e_wdata e_data
    v64.push_back(mk(0, 2'b00, 0, 64'h1003, 0, 64'h00000000_80000000, 0, 64'h1000, 8'h00, 0, 64'hFFFFFFFF_FFFFFF80));
    v64.push_back(mk(1, 2'b01, 0, 64'h2006, 64'hABCD, 0, 0, 64'h2000, 8'hC0, 64'hABCD0000_00000000, 0));
    v64.push_back(mk(0, 2'b10, 0, 64'h3002, 0, 0, 1, 0, 8'h00, 0, 0));
    v64.push_back(mk(0, 2'b00, 1, 64'h1003, 0, 64'h00000000_80000000, 0, 64'h1000, 8'h00, 0, 64'h80));
    v64.push_back(mk(0, 2'b01, 0, 64'h4002, 0, 64'h12345678_9ABCDEF0, 0, 64'h4000, 8'h00, 0, 64'hFFFFFFFF_FFFF9ABC));
    v64.push_back(mk(0, 2'b10, 1, 64'h5004, 0, 64'hDEADBEEF_00000000, 0, 64'h5000, 8'h00, 0, 64'h00000000_DEADBEEF));
    v64.push_back(mk(0, 2'b10, 0, 64'h5004, 0, 64'hDEADBEEF_00000000, 0, 64'h5000, 8'h00, 0, 64'hFFFFFFFF_DEADBEEF));
    v64.push_back(mk(0, 2'b11, 0, 64'h6000, 0, 64'h80000000_00000001, 0, 64'h6000, 8'h00, 0, 64'h80000000_00000001));
    v64.push_back(mk(1, 2'b00, 0, 64'h7005, 64'hFFFFFFFF_FFFFFF5A, 0, 0, 64'h7000, 8'h20, 64'hFFFF5A00_00000000, 0));
    v64.push_back(mk(1, 2'b10, 0, 64'h8004, 64'h11223344, 0, 0, 64'h8000, 8'hF0, 64'h11223344_00000000, 0));
    v64.push_back(mk(1, 2'b11, 0, 64'h9000, 64'h01020304_05060708, 0, 0, 64'h9000, 8'hFF, 64'h01020304_05060708, 0));
    v64.push_back(mk(1, 2'b01, 0, 64'h2001, 64'h55, 0, 1, 0, 8'h00, 0, 0));
    v64.push_back(mk(0, 2'b11, 0, 64'h6004, 0, 0, 1, 0, 8'h00, 0, 0));
    v64.push_back(mk(0, 2'b01, 1, 64'h400E, 0, 64'hBEEF0000_00000000, 0, 64'h4008, 8'h00, 0, 64'hBEEF));

    v32.push_back(mk(0, 2'b11, 0, 64'h0, 0, 0, 1, 0, 8'h0, 0, 0));
    v32.push_back(mk(0, 2'b10, 1, 64'h20, 0, 64'h80000000, 0, 64'h20, 8'h0, 0, 64'h80000000));
    v32.push_back(mk(0, 2'b01, 0, 64'h22, 0, 64'h87650000, 0, 64'h20, 8'h0, 0, 64'hFFFF8765));
    v32.push_back(mk(1, 2'b00, 0, 64'h13, 64'hAB, 0, 0, 64'h10, 8'h8, 64'hAB000000, 0));
    v32.push_back(mk(1, 2'b10, 0, 64'h21, 64'h1, 0, 1, 0, 8'h0, 0, 0));

    rst_n = 1'b0; sel32 = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_unsigned = 1'b0;
    req_size = 2'b00; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    step();
    step();
    chk("rst.ready64", 64'(a_ready), 64'd1);
    chk("rst.ready32", 64'(b_ready), 64'd1);
    chk("rst.memv", 64'(a_mem_valid), 64'd0);
    chk("rst.rv", 64'(a_resp_valid), 64'd0);
    chk("rst.addr", a_mem_addr, 64'd0);
    chk("rst.be", 64'(a_mem_be), 64'd0);
    chk("rst.data", a_resp_data, 64'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < v64.size(); i++) run(v64[i], $sformatf("v64_%0d", i));

    // Memory never accepts: four request cycles, then an error response.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 64'h100;
    step();
    req_addr = 64'h200; req_size = 2'b00;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_req.memv%0d", i), 64'(a_mem_valid), 64'd1);
      chk($sformatf("to_req.addr%0d", i), a_mem_addr, 64'h100);
      chk($sformatf("to_req.rv%0d", i), 64'(a_resp_valid), 64'd0);
      if (i == 2) req_valid = 1'b0;
      step();
    end
    chk("to_req.rv", 64'(a_resp_valid), 64'd1);
    chk("to_req.err", 64'(a_resp_err), 64'd1);
    chk("to_req.data", a_resp_data, 64'd0);
    chk("to_req.memv_off", 64'(a_mem_valid), 64'd0);
    step();
    chk("to_req.ready", 64'(a_ready), 64'd1);
    mem_rvalid = 1'b1; mem_rdata = '1;
    step();
    mem_rvalid = 1'b0;
    chk("to_req.late_rv", 64'(a_resp_valid), 64'd0);
    step();
    chk("to_req.late_rv2", 64'(a_resp_valid), 64'd0);

    // Read data never returns.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b11; req_addr = 64'h300;
    step();
    req_valid = 1'b0;
    chk("to_rd.memv", 64'(a_mem_valid), 64'd1);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_rd.rv%0d", i), 64'(a_resp_valid), 64'd0);
      step();
    end
    chk("to_rd.rv", 64'(a_resp_valid), 64'd1);
    chk("to_rd.err", 64'(a_resp_err), 64'd1);
    chk("to_rd.data", a_resp_data, 64'd0);
    step();
    chk("to_rd.ready", 64'(a_ready), 64'd1);

    // Reset while waiting for read data; the stale rvalid must be dropped.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 64'h10;
    step();
    req_valid = 1'b0;
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    chk("rst_wr.wait", 64'(a_resp_valid), 64'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_wr.ready", 64'(a_ready), 64'd1);
    chk("rst_wr.rv", 64'(a_resp_valid), 64'd0);
    chk("rst_wr.memv", 64'(a_mem_valid), 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 64'h5A;
    step();
    mem_rvalid = 1'b0;
    chk("rst_wr.stale_rv", 64'(a_resp_valid), 64'd0);
    step();
    chk("rst_wr.stale_rv2", 64'(a_resp_valid), 64'd0);
    run(mk(0, 2'b11, 1, 64'h8, 0, 64'hFEDCBA98_76543210, 0, 64'h8, 8'h00, 0, 64'hFEDCBA98_76543210), "rst_wr.ld");

    sel32 = 1'b1;
    for (int i = 0; i < v32.size(); i++) run(v32[i], $sformatf("v32_%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
